// File: rtl/conv_layer_stream.sv
// Streaming KxK convolution layer: raster-order pixel input over valid/ready,
// K-1 line buffers feeding a KxK window, NUM_KERNELS signed kernels applied
// in parallel with stride, arithmetic requantisation shift, saturation and
// optional ReLU. All channels leave together over a valid/ready handshake.
module conv_layer_stream #(
    parameter int    DATA_WIDTH  = 8,
    parameter int    KDATA_WIDTH = 8,
    parameter int    KERNEL_SIZE = 5,
    parameter int    IMGCOL      = 28,
    parameter int    IMGROW      = 28,
    parameter int    NUM_KERNELS = 2,
    parameter int    STRIDE      = 1,
    parameter int    ACC_WIDTH   = 24,
    parameter string ACTIVATION  = "RELU"
) (
    input  logic                                                                  clk,
    input  logic                                                                  rst,
    input  logic                                                                  start,
    input  logic [NUM_KERNELS-1:0][KERNEL_SIZE-1:0][KERNEL_SIZE-1:0][KDATA_WIDTH-1:0] kernel,
    input  logic [4:0]                                                            shift,
    input  logic                                                                  pix_valid,
    output logic                                                                  pix_ready,
    input  logic [DATA_WIDTH-1:0]                                                 pix_data,
    output logic                                                                  out_valid,
    input  logic                                                                  out_ready,
    output logic [NUM_KERNELS-1:0][DATA_WIDTH-1:0]                                out_data,
    output logic [15:0]                                                           out_row,
    output logic [15:0]                                                           out_col,
    output logic                                                                  busy,
    output logic                                                                  layer_done_out
);

    localparam int K     = KERNEL_SIZE;
    localparam int CW    = $clog2(IMGCOL);
    localparam int OROWS = (IMGROW - K) / STRIDE + 1;
    localparam int OCOLS = (IMGCOL - K) / STRIDE + 1;
    localparam bit C_RELU = (ACTIVATION == "RELU");

    localparam logic signed [ACC_WIDTH-1:0] C_UMAX = ACC_WIDTH'((64'd1 << DATA_WIDTH) - 64'd1);
    localparam logic signed [ACC_WIDTH-1:0] C_SMAX = ACC_WIDTH'((64'd1 << (DATA_WIDTH - 1)) - 64'd1);
    localparam logic signed [ACC_WIDTH-1:0] C_SMIN = ~C_SMAX;

    typedef enum logic [1:0] {
        S_IDLE,
        S_STREAM,
        S_DRAIN
    } state_t;

    state_t                                                         r_state;
    logic [NUM_KERNELS-1:0][K-1:0][K-1:0][KDATA_WIDTH-1:0]          r_kernel;
    logic [4:0]                                                     r_shift;
    logic [DATA_WIDTH-1:0]                                          r_lb [0:K-2][0:IMGCOL-1];
    logic [K-1:0][K-1:0][DATA_WIDTH-1:0]                            r_win;
    logic [15:0]                                                    r_row;
    logic [15:0]                                                    r_col;
    logic                                                           r_last_done;

    logic [K-1:0][K-1:0][DATA_WIDTH-1:0]                            w_win_next;
    logic [NUM_KERNELS-1:0][DATA_WIDTH-1:0]                         w_sat;
    logic signed [ACC_WIDTH-1:0]                                    w_acc;
    logic signed [ACC_WIDTH-1:0]                                    w_res;
    logic signed [ACC_WIDTH-1:0]                                    w_px;
    logic signed [ACC_WIDTH-1:0]                                    w_wt;
    logic [CW-1:0]                                                  w_cidx;
    logic                                                           w_pix_fire;
    logic                                                           w_out_fire;
    logic                                                           w_col_last;
    logic                                                           w_row_last;
    logic                                                           w_emit;
    logic                                                           w_out_last;

    assign pix_ready  = (r_state == S_STREAM) && (!out_valid || out_ready);
    assign busy       = (r_state != S_IDLE);
    assign w_pix_fire = pix_valid && pix_ready;
    assign w_out_fire = out_valid && out_ready;
    assign w_cidx     = r_col[CW-1:0];
    assign w_col_last = (r_col == 16'(IMGCOL - 1));
    assign w_row_last = (r_row == 16'(IMGROW - 1));
    assign w_emit     = (r_row >= 16'(K - 1)) && (r_col >= 16'(K - 1)) &&
                        (((r_row - 16'(K - 1)) % 16'(STRIDE)) == 16'd0) &&
                        (((r_col - 16'(K - 1)) % 16'(STRIDE)) == 16'd0);
    assign w_out_last = (out_row == 16'(OROWS - 1)) && (out_col == 16'(OCOLS - 1));

    // Next window: shift left, new rightmost column = buffered rows above plus the incoming pixel
    always_comb begin
        w_win_next = r_win;
        for (int unsigned i = 0; i < K; i++) begin
            for (int unsigned j = 0; j < K - 1; j++) begin
                w_win_next[i][j] = r_win[i][j+1];
            end
        end
        for (int unsigned i = 0; i < K - 1; i++) begin
            w_win_next[i][K-1] = r_lb[K-2-i][w_cidx];
        end
        w_win_next[K-1][K-1] = pix_data;
    end

    // Per-channel multiply-accumulate, arithmetic shift and saturation on the next window
    always_comb begin
        w_sat = '0;
        w_acc = '0;
        w_res = '0;
        w_px  = '0;
        w_wt  = '0;
        for (int unsigned ch = 0; ch < NUM_KERNELS; ch++) begin
            w_acc = '0;
            for (int unsigned i = 0; i < K; i++) begin
                for (int unsigned j = 0; j < K; j++) begin
                    w_px  = ACC_WIDTH'(w_win_next[i][j]);
                    w_wt  = ACC_WIDTH'(signed'(r_kernel[ch][i][j]));
                    w_acc = w_acc + w_px * w_wt;
                end
            end
            w_res = w_acc >>> r_shift;
            if (C_RELU) begin
                if (w_res[ACC_WIDTH-1])  w_sat[ch] = '0;
                else if (w_res > C_UMAX) w_sat[ch] = '1;
                else                     w_sat[ch] = w_res[DATA_WIDTH-1:0];
            end else begin
                if (w_res < C_SMIN)      w_sat[ch] = C_SMIN[DATA_WIDTH-1:0];
                else if (w_res > C_SMAX) w_sat[ch] = C_SMAX[DATA_WIDTH-1:0];
                else                     w_sat[ch] = w_res[DATA_WIDTH-1:0];
            end
        end
    end

    // Line buffers: the column at the write address rolls up one row per accepted pixel
    always_ff @(posedge clk) begin
        if (w_pix_fire) begin
            r_lb[0][w_cidx] <= pix_data;
            for (int unsigned k = 1; k < K - 1; k++) begin
                r_lb[k][w_cidx] <= r_lb[k-1][w_cidx];
            end
        end
    end

    // Frame control, pixel counters, window and registered output beat
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state        <= S_IDLE;
            r_kernel       <= '0;
            r_shift        <= '0;
            r_win          <= '0;
            r_row          <= '0;
            r_col          <= '0;
            r_last_done    <= 1'b0;
            out_valid      <= 1'b0;
            out_data       <= '0;
            out_row        <= '0;
            out_col        <= '0;
            layer_done_out <= 1'b0;
        end else begin
            layer_done_out <= 1'b0;
            if (w_out_fire) begin
                out_valid <= 1'b0;
                if (w_out_last) r_last_done <= 1'b1;
            end
            if (w_pix_fire) begin
                r_win <= w_win_next;
                if (w_col_last) begin
                    r_col <= '0;
                    r_row <= w_row_last ? '0 : r_row + 16'd1;
                end else begin
                    r_col <= r_col + 16'd1;
                end
                if (w_emit) begin
                    out_valid <= 1'b1;
                    out_data  <= w_sat;
                    out_row   <= (r_row - 16'(K - 1)) / 16'(STRIDE);
                    out_col   <= (r_col - 16'(K - 1)) / 16'(STRIDE);
                end
            end
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_kernel    <= kernel;
                        r_shift     <= shift;
                        r_row       <= '0;
                        r_col       <= '0;
                        r_win       <= '0;
                        r_last_done <= 1'b0;
                        r_state     <= S_STREAM;
                    end
                end
                S_STREAM: begin
                    if (w_pix_fire && w_col_last && w_row_last) r_state <= S_DRAIN;
                end
                S_DRAIN: begin
                    // The last output may already have left during STREAM when the
                    // final rows/columns are not on the stride grid.
                    if (r_last_done || (w_out_fire && w_out_last)) begin
                        r_state        <= S_IDLE;
                        layer_done_out <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
